// File: rtl/cnu_pkg.sv
// cnu_pkg: shared parameter defaults and width helpers for the comparator scheduler.
package cnu_pkg;

  localparam int unsigned R_DEF      = 4;
  localparam int unsigned D_DEF      = 5;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned IDX_W_DEF  = 8;
  localparam int unsigned TAG_W_DEF  = 6;
  localparam int unsigned FD_DEF     = 2;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Bits needed to index v items, never less than one.
  function automatic int unsigned idx_bits(input int unsigned v);
    return (v > 1) ? clog2(v) : 1;
  endfunction

endpackage

// File: rtl/cmp_tree.sv
// cmp_tree: smallest and second-smallest value of a row, one registered stage.
// Ties resolve to the lowest position; padding lanes are all-ones, so they
// never displace a real value and min2 stays all-ones when D = 1.
module cmp_tree #(
  parameter int unsigned data_w = 8,
  parameter int unsigned idx_w  = 8,
  parameter int unsigned D      = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic [D*data_w-1:0]   data_i,
  output logic [data_w-1:0]     min_o,
  output logic [data_w-1:0]     min2_o,
  output logic [idx_w-1:0]      min_idx_o
);

  logic [data_w-1:0] min_d, min2_d, v;
  logic [idx_w-1:0]  idx_d;
  logic [data_w-1:0] min_q, min2_q;
  logic [idx_w-1:0]  idx_q;

  // Reduce the row to (min, min2, argmin), keeping the earliest index on ties.
  always_comb begin
    min_d  = '1;
    min2_d = '1;
    idx_d  = '0;
    v      = '0;
    for (int unsigned i = 0; i < D; i++) begin
      v = data_i[i*data_w +: data_w];
      if (v < min_d) begin
        min2_d = min_d;
        min_d  = v;
        idx_d  = idx_w'(i);
      end else if (v < min2_d) begin
        min2_d = v;
      end
    end
  end

  // Result register, loaded only when a row is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_q  <= '0;
      min2_q <= '0;
      idx_q  <= '0;
    end else if (en_i) begin
      min_q  <= min_d;
      min2_q <= min2_d;
      idx_q  <= idx_d;
    end
  end

  assign min_o     = min_q;
  assign min2_o    = min2_q;
  assign min_idx_o = idx_q;

endmodule

// File: rtl/cmp_sched.sv
// cmp_sched: round-robin arbitration of R requesters onto one cmp_tree, with a
// credit-limited output FIFO so a granted result always has a slot to land in.
module cmp_sched
  import cnu_pkg::*;
#(
  parameter int unsigned R      = R_DEF,
  parameter int unsigned D      = D_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned IDX_W  = IDX_W_DEF,
  parameter int unsigned TAG_W  = TAG_W_DEF,
  parameter int unsigned FD     = FD_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [R-1:0]           req,
  input  logic [R*D*DATA_W-1:0]  in_data,
  input  logic [R*TAG_W-1:0]     in_tag,
  input  logic [R-1:0]           cfg_mask,
  output logic [R-1:0]           gnt,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_min,
  output logic [DATA_W-1:0]      out_min2,
  output logic [IDX_W-1:0]       out_min_idx,
  output logic [TAG_W-1:0]       out_tag,
  output logic [idx_bits(R)-1:0] out_src
);

  localparam int unsigned SRC_W = idx_bits(R);
  localparam int unsigned CNT_W = idx_bits(FD + 1);
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam int unsigned ROW_W = D * DATA_W;

  typedef struct packed {
    logic [DATA_W-1:0] mn;
    logic [DATA_W-1:0] mn2;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [SRC_W-1:0]  src;
  } res_t;

  logic [SRC_W-1:0] ptr_q, win;
  logic             inflight_q;
  logic [TAG_W-1:0] tag_q, sel_tag;
  logic [SRC_W-1:0] src_q;
  logic [CNT_W-1:0] count_q, count_d, wr_idx;
  logic             valid_q;
  res_t             fifo_q [FD];
  res_t             push_entry;
  logic [R-1:0]     elig;
  logic             found, push, pop, credit_ok;
  logic [ROW_W-1:0] sel_data;
  int unsigned      cand;
  logic [DATA_W-1:0] t_min, t_min2;
  logic [IDX_W-1:0]  t_idx;

  assign elig      = req & cfg_mask;
  assign pop       = valid_q & out_ready;
  assign push      = inflight_q;
  // Slots already promised (buffered + in flight) must stay below FD, counting a same-cycle pop.
  assign credit_ok = (SUM_W'(count_q) + SUM_W'(inflight_q)) < (SUM_W'(FD) + SUM_W'(pop));

  // Round-robin search from ptr; the winner's row and tag are muxed toward the tree.
  always_comb begin
    gnt      = '0;
    win      = '0;
    found    = 1'b0;
    cand     = '0;
    sel_data = '0;
    sel_tag  = '0;
    for (int unsigned k = 0; k < R; k++) begin
      cand = 32'(ptr_q) + k;
      if (cand >= R) cand = cand - R;
      if (!found && !rst && credit_ok && elig[cand]) begin
        found     = 1'b1;
        win       = SRC_W'(cand);
        gnt[cand] = 1'b1;
        sel_data  = in_data[cand*ROW_W +: ROW_W];
        sel_tag   = in_tag[cand*TAG_W +: TAG_W];
      end
    end
  end

  // Pointer and in-flight stage: tag/source ride alongside the tree's register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= '0;
      inflight_q <= 1'b0;
      tag_q      <= '0;
      src_q      <= '0;
    end else begin
      inflight_q <= found;
      if (found) begin
        ptr_q <= (32'(win) == R - 1) ? '0 : win + SRC_W'(1);
        tag_q <= sel_tag;
        src_q <= win;
      end
    end
  end

  cmp_tree #(
    .data_w (DATA_W),
    .idx_w  (IDX_W),
    .D      (D)
  ) u_tree (
    .clk       (clk),
    .rst       (rst),
    .en_i      (found),
    .data_i    (sel_data),
    .min_o     (t_min),
    .min2_o    (t_min2),
    .min_idx_o (t_idx)
  );

  assign push_entry = '{mn: t_min, mn2: t_min2, idx: t_idx, tag: tag_q, src: src_q};
  assign count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
  assign wr_idx     = pop ? count_q - CNT_W'(1) : count_q;

  // Shift-register FIFO: entry 0 is the head and drives out_* directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < FD; i++) fifo_q[i] <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      if (pop) begin
        for (int unsigned i = 0; i + 1 < FD; i++) fifo_q[i] <= fifo_q[i+1];
      end
      if (push) fifo_q[wr_idx] <= push_entry;
      count_q <= count_d;
      valid_q <= (count_d != '0);
    end
  end

  assign out_valid   = valid_q;
  assign out_min     = fifo_q[0].mn;
  assign out_min2    = fifo_q[0].mn2;
  assign out_min_idx = fifo_q[0].idx;
  assign out_tag     = fifo_q[0].tag;
  assign out_src     = fifo_q[0].src;

endmodule

// File: tb/tb_cmp_sched.sv
// tb_cmp_sched: randomized and directed checks of cmp_sched against a queue-based model.
module tb_cmp_sched;
  import cnu_pkg::*;

  localparam int unsigned R  = 4;
  localparam int unsigned D  = 5;
  localparam int unsigned DW = 8;
  localparam int unsigned IW = 8;
  localparam int unsigned TW = 6;
  localparam int unsigned FD = 2;
  localparam int unsigned SW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [R-1:0]      req, cfg_mask, gnt;
  logic [R*D*DW-1:0] in_data;
  logic [R*TW-1:0]   in_tag;
  logic              out_valid, out_ready;
  logic [DW-1:0]     out_min, out_min2;
  logic [IW-1:0]     out_min_idx;
  logic [TW-1:0]     out_tag;
  logic [SW-1:0]     out_src;

  always #5 clk = ~clk;

  cmp_sched #(.R(R), .D(D), .DATA_W(DW), .IDX_W(IW), .TAG_W(TW), .FD(FD)) dut (
    .clk(clk), .rst(rst), .req(req), .in_data(in_data), .in_tag(in_tag),
    .cfg_mask(cfg_mask), .gnt(gnt), .out_valid(out_valid), .out_ready(out_ready),
    .out_min(out_min), .out_min2(out_min2), .out_min_idx(out_min_idx),
    .out_tag(out_tag), .out_src(out_src)
  );

  // Model: every granted-but-not-consumed result, oldest first, with the cycle it becomes visible.
  typedef struct {
    logic [DW-1:0] mn;
    logic [DW-1:0] mn2;
    logic [IW-1:0] idx;
    logic [TW-1:0] tag;
    int            src;
    int            due;
  } exp_t;

  exp_t         q[$];
  int           m_ptr, cyc, e_win, checks, failures;
  logic [R-1:0] e_gnt, pend;
  logic         e_valid, e_pop;

  function automatic exp_t row_result(input int r);
    exp_t          e;
    logic [DW-1:0] v [D];
    int            bi;
    for (int i = 0; i < int'(D); i++) v[i] = in_data[(r*int'(D)+i)*int'(DW) +: DW];
    bi = 0;
    for (int i = 1; i < int'(D); i++) if (v[i] < v[bi]) bi = i;
    e.mn  = v[bi];
    e.idx = IW'(bi);
    e.mn2 = '1;
    for (int i = 0; i < int'(D); i++) if (i != bi && v[i] < e.mn2) e.mn2 = v[i];
    e.tag = in_tag[r*int'(TW) +: TW];
    e.src = r;
    e.due = cyc + 2;
    return e;
  endfunction

  function automatic void m_eval();
    int r;
    e_valid = !rst && q.size() > 0 && q[0].due <= cyc;
    e_pop   = e_valid && out_ready;
    e_gnt   = '0;
    e_win   = -1;
    if (!rst && (int'(FD) - q.size() + (e_pop ? 1 : 0)) > 0) begin
      for (int k = 0; k < int'(R); k++) begin
        r = (m_ptr + k) % int'(R);
        if (e_win < 0 && req[r] && cfg_mask[r]) begin
          e_gnt[r] = 1'b1;
          e_win    = r;
        end
      end
    end
  endfunction

  task automatic next_cycle();
    if (e_pop) void'(q.pop_front());
    if (e_win >= 0) begin
      q.push_back(row_result(e_win));
      m_ptr = (e_win + 1) % int'(R);
    end
    pend &= ~e_gnt;
    cyc++;
    @(negedge clk);
  endtask

  task automatic refresh_inputs(input int p);
    for (int r = 0; r < int'(R); r++) begin
      if (!pend[r]) begin
        if (int'($urandom_range(99)) < p) begin
          pend[r] = 1'b1;
          req[r]  = 1'b1;
          for (int i = 0; i < int'(D); i++)
            in_data[(r*int'(D)+i)*int'(DW) +: DW] = ($urandom_range(3) == 0) ? {DW{1'b1}} : DW'($urandom_range(20));
          in_tag[r*int'(TW) +: TW] = TW'($urandom);
        end else begin
          req[r] = 1'b0;
        end
      end
    end
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    req   = '0;
    pend  = '0;
    q.delete();
    m_ptr = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '1; cfg_mask = '1; out_ready = 1'b1;
    @(negedge clk); #1;
    checks++; if (gnt !== '0) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if ({out_min, out_min2, out_min_idx, out_tag, out_src} !== '0) begin
      failures++; $display("FAIL reset_outs got=%0d/%0d/%0d/%0d/%0d exp=0", out_min, out_min2, out_min_idx, out_tag, out_src);
    end
    do_reset();
  endtask

  task automatic test_single();
    logic [DW-1:0] row [5] = '{8'd9, 8'd3, 8'd7, 8'd3, 8'd12};
    do_reset();
    cfg_mask = '1; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) in_data[(2*int'(D)+i)*int'(DW) +: DW] = row[i];
    in_tag[2*TW +: TW] = 6'd5;
    pend = 4'b0100;
    for (int c = 0; c < 4; c++) begin
      req = pend;
      #1; m_eval();
      checks++; if (gnt !== e_gnt) begin failures++; $display("FAIL single_gnt cyc=%0d got=%b exp=%b", cyc, gnt, e_gnt); end
      checks++; if (out_valid !== e_valid) begin failures++; $display("FAIL single_valid cyc=%0d got=%b exp=%b", cyc, out_valid, e_valid); end
      if (c == 0) begin
        checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL single_gnt0 got=%b exp=0100", gnt); end
      end
      if (c == 1) begin
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_early got=%b exp=0", out_valid); end
      end
      if (c == 2) begin
        checks++;
        if (out_valid !== 1'b1 || out_min !== 8'd3 || out_min2 !== 8'd3 || out_min_idx !== 8'd1 || out_tag !== 6'd5 || out_src !== 2'd2) begin
          failures++;
          $display("FAIL single_result got=v%b %0d/%0d/%0d/%0d/%0d exp=v1 3/3/1/5/2", out_valid, out_min, out_min2, out_min_idx, out_tag, out_src);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    cfg_mask = '1; out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      refresh_inputs(100);
      #1; m_eval();
      checks++; if (gnt !== e_gnt) begin failures++; $display("FAIL rr_gnt cyc=%0d got=%b exp=%b", cyc, gnt, e_gnt); end
      checks++; if (gnt !== (4'b0001 << (c % 4))) begin failures++; $display("FAIL rr_order c=%0d got=%b", c, gnt); end
      checks++; if (out_valid !== e_valid) begin failures++; $display("FAIL rr_valid cyc=%0d got=%b exp=%b", cyc, out_valid, e_valid); end
      if (e_valid) begin
        checks++;
        if (out_min !== q[0].mn || out_min2 !== q[0].mn2 || out_min_idx !== q[0].idx || out_tag !== q[0].tag || out_src !== SW'(q[0].src)) begin
          failures++;
          $display("FAIL rr_result cyc=%0d got=%0d/%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d/%0d", cyc, out_min, out_min2, out_min_idx, out_tag, out_src,
                   q[0].mn, q[0].mn2, q[0].idx, q[0].tag, q[0].src);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    cfg_mask = '1;
    for (int c = 0; c < 16; c++) begin
      out_ready = (c < 3 || c >= 10);
      refresh_inputs(100);
      #1; m_eval();
      checks++; if (gnt !== e_gnt) begin failures++; $display("FAIL bp_gnt cyc=%0d got=%b exp=%b", cyc, gnt, e_gnt); end
      checks++; if (out_valid !== e_valid) begin failures++; $display("FAIL bp_valid cyc=%0d got=%b exp=%b", cyc, out_valid, e_valid); end
      if (e_valid) begin
        checks++;
        if (out_min !== q[0].mn || out_min2 !== q[0].mn2 || out_min_idx !== q[0].idx || out_tag !== q[0].tag || out_src !== SW'(q[0].src)) begin
          failures++;
          $display("FAIL bp_result cyc=%0d got=%0d/%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d/%0d", cyc, out_min, out_min2, out_min_idx, out_tag, out_src,
                   q[0].mn, q[0].mn2, q[0].idx, q[0].tag, q[0].src);
        end
      end
      if (c >= 3 && c <= 9) begin
        checks++; if (gnt !== '0 || out_valid !== 1'b1 || out_src !== 2'd1) begin
          failures++; $display("FAIL bp_stall c=%0d got=gnt%b v%b src%0d exp=gnt0000 v1 src1", c, gnt, out_valid, out_src);
        end
      end
      if (c == 10) begin
        checks++; if (gnt !== 4'b1000 || out_src !== 2'd1) begin
          failures++; $display("FAIL bp_resume got=gnt%b src%0d exp=gnt1000 src1", gnt, out_src);
        end
      end
      if (c == 11) begin
        checks++; if (out_valid !== 1'b1 || out_src !== 2'd2) begin
          failures++; $display("FAIL bp_drain2 got=v%b src%0d exp=v1 src2", out_valid, out_src);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_mask();
    do_reset();
    cfg_mask = 4'b1010; out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      refresh_inputs(100);
      #1; m_eval();
      checks++; if (gnt !== e_gnt) begin failures++; $display("FAIL mask_gnt cyc=%0d got=%b exp=%b", cyc, gnt, e_gnt); end
      checks++; if (gnt !== ((c % 2 == 0) ? 4'b0010 : 4'b1000)) begin failures++; $display("FAIL mask_alt c=%0d got=%b", c, gnt); end
      checks++; if (out_valid !== e_valid) begin failures++; $display("FAIL mask_valid cyc=%0d got=%b exp=%b", cyc, out_valid, e_valid); end
      if (e_valid) begin
        checks++; if (out_src !== SW'(q[0].src) || out_min !== q[0].mn || out_tag !== q[0].tag) begin
          failures++; $display("FAIL mask_result cyc=%0d got=src%0d min%0d tag%0d exp=src%0d min%0d tag%0d", cyc, out_src, out_min, out_tag,
                               q[0].src, q[0].mn, q[0].tag);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_midop();
    do_reset();
    cfg_mask = '1;
    for (int c = 0; c < 6; c++) begin
      out_ready = (c < 3);
      refresh_inputs(100);
      #1; m_eval();
      checks++; if (gnt !== e_gnt) begin failures++; $display("FAIL rstmid_pre_gnt cyc=%0d got=%b exp=%b", cyc, gnt, e_gnt); end
      next_cycle();
    end
    rst = 1'b1;
    q.delete();
    m_ptr = 0;
    #1; m_eval();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", out_valid); end
    checks++; if (gnt !== '0 || {out_min, out_min2, out_min_idx, out_tag, out_src} !== '0) begin
      failures++; $display("FAIL rstmid_outs got=gnt%b %0d/%0d/%0d/%0d/%0d exp=0", gnt, out_min, out_min2, out_min_idx, out_tag, out_src);
    end
    next_cycle();
    #1; m_eval();
    next_cycle();
    rst = 1'b0; req = '0; pend = '0; out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c >= 3) refresh_inputs(100);
      #1; m_eval();
      checks++; if (gnt !== e_gnt) begin failures++; $display("FAIL rstmid_gnt cyc=%0d got=%b exp=%b", cyc, gnt, e_gnt); end
      checks++; if (out_valid !== e_valid) begin failures++; $display("FAIL rstmid_post_valid cyc=%0d got=%b exp=%b", cyc, out_valid, e_valid); end
      if (c < 5) begin
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_quiet c=%0d got=%b exp=0", c, out_valid); end
      end
      if (c == 3) begin
        checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL rstmid_ptr got=%b exp=0001", gnt); end
      end
      next_cycle();
    end
  endtask

  task automatic test_random();
    do_reset();
    cfg_mask = '1;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(15) == 0) cfg_mask = R'($urandom);
      out_ready = ($urandom_range(9) < 7);
      refresh_inputs(60);
      #1; m_eval();
      checks++; if (gnt !== e_gnt) begin failures++; $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", cyc, gnt, e_gnt); end
      checks++; if (out_valid !== e_valid) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, out_valid, e_valid); end
      if (e_valid) begin
        checks++;
        if (out_min !== q[0].mn || out_min2 !== q[0].mn2 || out_min_idx !== q[0].idx || out_tag !== q[0].tag || out_src !== SW'(q[0].src)) begin
          failures++;
          $display("FAIL rnd_result cyc=%0d got=%0d/%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d/%0d", cyc, out_min, out_min2, out_min_idx, out_tag, out_src,
                   q[0].mn, q[0].mn2, q[0].idx, q[0].tag, q[0].src);
        end
      end
      next_cycle();
    end
  endtask

  initial begin
    rst = 1'b1; req = '0; cfg_mask = '1; in_data = '0; in_tag = '0; out_ready = 1'b1;
    pend = '0; cyc = 0; m_ptr = 0; checks = 0; failures = 0;
    e_gnt = '0; e_win = -1; e_pop = 1'b0; e_valid = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_mask();
    test_reset_midop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cmp_sched.md
CMP_SCHED -- requirements
Module: cmp_sched

Interface
REQ-001 Parameter R, default 4: number of requesters sharing one minimum-finder tree.
REQ-002 Parameter D, default 5: values per row, the tree's input width in elements.
REQ-003 Parameter DATA_W, default 8: magnitude width.
REQ-004 Parameter IDX_W, default 8: index width.
REQ-005 Parameter TAG_W, default 6: row tag width.
REQ-006 Parameter FD, default 2: output FIFO depth.
REQ-007 Clock and reset SHALL be as follows: one clock; reset is asynchronous and active-high.
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
REQ-008 Requester and output ports SHALL be:
- req  in  R  per-requester request.
- in_data  in  R*D*DATA_W  row magnitudes; requester r occupies slice r.
- in_tag  in  R*TAG_W  row tag per requester.
- cfg_mask  in  R  1 = requester enabled.
- gnt  out  R  one-hot accept, combinational, same cycle as req.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accept.
- out_min  out  DATA_W  smallest value of the row.
- out_min2  out  DATA_W  second-smallest value of the row.
- out_min_idx  out  IDX_W  position of the minimum within the row.
- out_tag  out  TAG_W  tag of the source row.
- out_src  out  clog2(R)  index of the granted requester.

Function
REQ-009 A requester r is eligible when req[r] and cfg_mask[r] are both 1.
REQ-010 A grant SHALL be issued only when credit > 0, where credit = FD - fifo_count - inflight + (out_valid & out_ready).
REQ-011 Round-robin arbitration: search starts at ptr; the first eligible requester wins; ptr becomes winner+1 modulo R.
- ptr is unchanged when no grant is issued.
REQ-012 gnt SHALL be at most one-hot and 0 whenever no grant is issued; a requester holds req, data and tag stable until its gnt.
REQ-013 In the grant cycle:
- the winner's in_data slice is muxed to the tree input;
- tree en is driven to 1;
- winner tag and index are registered into the in-flight stage; inflight is set to 1.
REQ-014 The tree has one registered stage, so the result SHALL be pushed into the FIFO exactly one cycle after the grant, with its tag and source index; inflight then clears unless a new grant is issued.
REQ-015 Latency SHALL be as follows:
- from gnt to out_valid is 2 cycles when the FIFO is empty;
- the result appears on out_* in the same cycle as out_valid (FIFO head, registered).
REQ-016 Throughput SHALL be one grant per cycle while out_ready = 1 and eligible requests exist.
REQ-017 out_* SHALL remain stable while out_valid & !out_ready.
REQ-018 A push and a pop in the same cycle SHALL leave fifo_count unchanged; a push into a full FIFO is impossible by construction of the credit rule.
REQ-019 Results SHALL leave in grant order.
REQ-020 When D is odd, the tree's padding is all-ones; if D = 1, out_min2 SHALL be all-ones.
REQ-021 A cfg_mask change takes effect in the same cycle; in-flight results of a newly masked requester SHALL still be delivered.
REQ-022 A combinational path from out_ready to gnt is permitted; there is no combinational path from req to out_*.

Reset
REQ-023 rst SHALL force the following:
- gnt = 0 (combinationally), ptr = 0, inflight = 0;
- FIFO empty, out_valid = 0;
- out_min, out_min2, out_min_idx, out_tag, out_src = 0;
- tree registers cleared.
REQ-024 A reset asserted mid-operation SHALL discard in-flight and buffered results; no result is emitted after reset release without a new grant.

Structure
REQ-025 The default parameter values and the clog2 function SHALL live in a shared package, cnu_pkg.
REQ-026 The existing comparator tree SHALL be instantiated once as sub-module cmp_tree with matching data_w, idx_w and D.
REQ-027 Arbiter, in-flight register, and FIFO with credit counter SHALL be in cmp_sched itself.

Verification
REQ-028 Single request, D=5: requester 2 offers {9,3,7,3,12}, tag 5, out_ready = 1.
- gnt = 0100 in cycle 0;
- cycle 2: out_valid with min 3, min2 3, idx 1 or 3 consistent with tree tie rule, tag 5, src 2.
REQ-029 All 4 requesting continuously with ready = 1: grants 0,1,2,3,0,... one per cycle, with no gap.
REQ-030 Backpressure: out_ready = 0 from cycle 3.
- exactly FD = 2 results are buffered;
- gnt = 0 afterwards;
- on ready = 1, both drain in order and granting resumes in the same cycle.
REQ-031 Mask: cfg_mask = 1010 with all req = 1: only requesters 1 and 3 are granted, alternating.
REQ-032 Reset during traffic: assert rst with 2 results buffered.
- out_valid drops immediately;
- after release, no output appears until a new grant;
- ptr restarts at 0.
